// File: rtl/sdp_ram_pkg.sv
// rtl/sdp_ram_pkg.sv - shared types and constants for the byte-enable simple-dual-port RAM
// Purpose: clear-sequencer state encoding and read-during-write policy selectors.
// Ports: none (package).
package sdp_ram_pkg;

  // Clear sequencer states: CLEAR zero-fills the array, RUN serves the user ports.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_t;

  // Same-address read/write policy selectors for RDW_MODE.
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/sdp_ram_if.sv
// rtl/sdp_ram_if.sv - port bundle for sdp_ram_be
// Purpose: groups the RAM ports; modport dut is the RAM-side view.
// Ports: clk (input to the interface); all other signals are interface members.
interface sdp_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input logic clk
);

  logic                  rst;
  logic                  clr_req;
  logic                  busy;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W/8-1:0]   wr_be;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;

  modport dut (
    input  clk,
    input  rst,
    input  clr_req,
    output busy,
    input  wr_en,
    input  wr_addr,
    input  wr_be,
    input  wr_data,
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/sdp_ram_clr_ctrl.sv
// rtl/sdp_ram_clr_ctrl.sv - clear sequencer for sdp_ram_be
// Purpose: zero-fills every word after reset or on clr_req, one word per cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr_req    start a clear (honoured only in RUN)
//   busy       registered, high for exactly DEPTH cycles per clear
//   clr_we     array write strobe for the zero fill
//   clr_addr   word being zeroed this cycle
module sdp_ram_clr_ctrl
  import sdp_ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  // busy mirrors the CLEAR state but is kept as its own register so it is a
  // clean flop output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          // The last word is written this cycle; the counter wraps back to 0.
          if (cnt == {ADDR_W{1'b1}}) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/sdp_ram_be.sv
// rtl/sdp_ram_be.sv - simple-dual-port RAM with byte enables, read latency 1/2 and clear
// Purpose: one write port and one read port on a single clock; self-clearing after reset.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   clr_req / busy     clear request / clear in progress (user ports ignored)
//   wr_en, wr_addr, wr_be, wr_data   byte-masked write
//   rd_en, rd_addr     read request
//   rd_data, rd_valid  read result RD_LAT cycles after rd_en; rd_data holds otherwise
module sdp_ram_be
  import sdp_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = RDW_OLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  output logic                busy,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  generate
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
      $error("sdp_ram_be: DATA_W must be a non-zero multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("sdp_ram_be: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sdp_ram_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr_ctrl (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User strobes are dead while the clear runs.
  logic wr_ok;
  logic rd_ok;
  assign wr_ok = wr_en & ~busy;
  assign rd_ok = rd_en & ~busy;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single write path: the zero fill and user writes never overlap because
  // wr_ok is masked by busy, so the priority here only documents intent.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read word with optional write-first bypass of the enabled bytes.
  logic [DATA_W-1:0] rd_word;
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == RDW_NEW && wr_ok && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  // First read stage: data only loads on a read so it holds between results.
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) begin
        s1_data <= rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] s2_data;
      logic              s2_valid;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end
      assign rd_data  = s2_data;
      assign rd_valid = s2_valid;
    end else begin : g_lat1
      assign rd_data  = s1_data;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule
